// File: rtl/cond_eval_unit.sv
// Condition-execution unit: owns NZCV, evaluates ARM condition codes, stalls
// conditional requests behind in-flight flag setters. Optional: FLAG_BYPASS_EN.
module cond_eval_unit #(
  parameter int          MAX_PEND     = 3,
  parameter logic [3:0]  RESET_STATUS = 4'b0000,
  localparam int         CNT_W        = $clog2(MAX_PEND + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_issue,
  input  logic             status_we,
  input  logic [3:0]       status_in,
  input  logic             req_valid,
  input  logic [3:0]       req_cond,
  output logic             req_ready,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_illegal,
  output logic [3:0]       status_out,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             pend_full
);

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2,
                         COND_CC = 4'h3, COND_MI = 4'h4, COND_PL = 4'h5,
                         COND_VS = 4'h6, COND_VC = 4'h7, COND_HI = 4'h8,
                         COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                         COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE,
                         COND_NV = 4'hF;

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [3:0] status_q;
  logic [3:0] eff_flags;
  logic       flag_free;
  logic       pend_inc, pend_dec;
  logic       accept;
  logic       cond_pass;
  logic       n, z, c, v;

  assign status_out = status_q;
  assign pend_full  = (pend_cnt == PEND_MAX);
  assign flag_free  = (req_cond == COND_AL) || (req_cond == COND_NV);

  // Same-cycle flag_issue belongs to the requester itself, so ready only
  // looks at the counter as it stood at the start of the cycle.
`ifdef FLAG_BYPASS_EN
  assign eff_flags = status_we ? status_in : status_q;
  assign req_ready = flag_free || (pend_cnt == '0) ||
                     ((pend_cnt == PEND_ONE) && status_we);
`else
  assign eff_flags = status_q;
  assign req_ready = flag_free || ((pend_cnt == '0) && !status_we);
`endif

  assign {n, z, c, v} = eff_flags;
  assign accept       = req_valid && req_ready;
  assign pend_inc     = flag_issue && !pend_full;
  assign pend_dec     = status_we && (pend_cnt != '0);

  always_comb begin
    cond_pass = 1'b0;
    case (req_cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q    <= RESET_STATUS;
      pend_cnt    <= '0;
      res_valid   <= 1'b0;
      res_taken   <= 1'b0;
      res_illegal <= 1'b0;
    end else begin
      if (status_we) status_q <= status_in;
      if (pend_inc && !pend_dec)      pend_cnt <= pend_cnt + PEND_ONE;
      else if (pend_dec && !pend_inc) pend_cnt <= pend_cnt - PEND_ONE;
      res_valid <= accept;
      if (accept) begin
        res_taken   <= cond_pass;
        res_illegal <= (req_cond == COND_NV);
      end
    end
  end

endmodule

// File: tb/tb_cond_eval_unit.sv
// Directed bench for cond_eval_unit; expectations follow the build's
// FLAG_BYPASS_EN setting.
module tb_cond_eval_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_issue, status_we, req_valid;
  logic [3:0] status_in, req_cond;
  logic       req_ready, res_valid, res_taken, res_illegal;
  logic [3:0] status_out;
  logic [1:0] pend_cnt;
  logic       pend_full;

  int total = 0;
  int bad   = 0;

  cond_eval_unit #(.MAX_PEND(3), .RESET_STATUS(4'b0000)) dut (
    .clk(clk), .rst(rst), .flag_issue(flag_issue), .status_we(status_we),
    .status_in(status_in), .req_valid(req_valid), .req_cond(req_cond),
    .req_ready(req_ready), .res_valid(res_valid), .res_taken(res_taken),
    .res_illegal(res_illegal), .status_out(status_out), .pend_cnt(pend_cnt),
    .pend_full(pend_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference table written straight from the ARM condition definitions.
  function automatic logic ref_taken(input logic [3:0] cc, input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (cc)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fn;
      4'd5:  return !fn;
      4'd6:  return fv;
      4'd7:  return !fv;
      4'd8:  return fc && !fz;
      4'd9:  return !fc || fz;
      4'd10: return fn ~^ fv;
      4'd11: return fn ^ fv;
      4'd12: return !fz && (fn ~^ fv);
      4'd13: return fz || (fn ^ fv);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    rst = 1'b1; flag_issue = 1'b0; status_we = 1'b0; status_in = 4'h0;
    req_valid = 1'b0; req_cond = 4'h0;
    step(); step();
    rst = 1'b0;
    chk("rst_status", status_out, 4'b0000);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_full", pend_full, 0);
    chk("rst_valid", res_valid, 0);

    // 1: EQ with Z set
    status_we = 1'b1; status_in = 4'b0100;
    step();
    status_we = 1'b0;
    req_valid = 1'b1; req_cond = 4'h0;
    #1 chk("t1_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("t1_valid", res_valid, 1);
    chk("t1_taken", res_taken, 1);
    chk("t1_illegal", res_illegal, 0);
    step();
    chk("t1_valid_drop", res_valid, 0);

    // 2: NE stalled behind one flag setter
    flag_issue = 1'b1;
    step();
    flag_issue = 1'b0;
    chk("t2_pend1", pend_cnt, 1);
    req_valid = 1'b1; req_cond = 4'h1;
    #1 chk("t2_stall_a", req_ready, 0);
    step();
    chk("t2_noresult", res_valid, 0);
    #1 chk("t2_stall_b", req_ready, 0);
    step();
    status_we = 1'b1; status_in = 4'b0000;
`ifdef FLAG_BYPASS_EN
    #1 chk("t2_bypass_ready", req_ready, 1);
    step();
    status_we = 1'b0; req_valid = 1'b0;
`else
    #1 chk("t2_wb_stall", req_ready, 0);
    step();
    status_we = 1'b0;
    chk("t2_noresult_wb", res_valid, 0);
    #1 chk("t2_late_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
`endif
    chk("t2_valid", res_valid, 1);
    chk("t2_taken", res_taken, 1);
    chk("t2_pend0", pend_cnt, 0);

    // 3: saturate the pending counter, then drain
    flag_issue = 1'b1;
    for (int i = 0; i < 4; i++) step();
    flag_issue = 1'b0;
    chk("t3_pend_sat", pend_cnt, 3);
    chk("t3_full", pend_full, 1);
    status_we = 1'b1; status_in = 4'b0000;
    step();
    chk("t3_pend2", pend_cnt, 2);
    chk("t3_notfull", pend_full, 0);
    step(); step();
    chk("t3_pend_drained", pend_cnt, 0);
    step();
    status_we = 1'b0;
    chk("t3_pend_floor", pend_cnt, 0);

    // 4: full table sweep with no pending setters
    for (int s = 0; s < 16; s++) begin
      status_we = 1'b1; status_in = 4'(s); req_valid = 1'b0;
      step();
      status_we = 1'b0;
      for (int cc = 0; cc < 16; cc++) begin
        req_valid = 1'b1; req_cond = 4'(cc);
        #1 chk($sformatf("t4_ready_%0h_%0h", cc, s), req_ready, 1);
        step();
        chk($sformatf("t4_valid_%0h_%0h", cc, s), res_valid, 1);
        chk($sformatf("t4_taken_%0h_%0h", cc, s), res_taken, ref_taken(4'(cc), 4'(s)));
        chk($sformatf("t4_illegal_%0h_%0h", cc, s), res_illegal, (cc == 15) ? 1 : 0);
      end
    end
    req_valid = 1'b0;
    // hand-checked spot cases
    status_we = 1'b1; status_in = 4'b0110;
    step();
    status_we = 1'b0; req_valid = 1'b1; req_cond = 4'h9;
    step();
    chk("t4_ls_0110", res_taken, 1);
    status_we = 1'b1; status_in = 4'b1000; req_valid = 1'b0;
    step();
    status_we = 1'b0; req_valid = 1'b1; req_cond = 4'hD;
    step();
    chk("t4_le_1000", res_taken, 1);
    req_cond = 4'hF;
    step();
    req_valid = 1'b0;
    chk("t4_nv_illegal", res_illegal, 1);
    chk("t4_nv_taken", res_taken, 0);

    // 5: issue+writeback same cycle, flag-free codes while pending
    flag_issue = 1'b1;
    step();
    chk("t5_pend1", pend_cnt, 1);
    status_we = 1'b1; status_in = 4'b1010;
    step();
    flag_issue = 1'b0; status_we = 1'b0;
    chk("t5_pend_hold", pend_cnt, 1);
    chk("t5_status", status_out, 4'b1010);
    req_valid = 1'b1; req_cond = 4'hE;
    #1 chk("t5_al_ready", req_ready, 1);
    step();
    chk("t5_al_valid", res_valid, 1);
    chk("t5_al_taken", res_taken, 1);
    req_cond = 4'hF;
    #1 chk("t5_nv_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("t5_nv_illegal", res_illegal, 1);
    status_we = 1'b1;
    step();
    status_we = 1'b0;
    chk("t5_drain", pend_cnt, 0);
    // younger flag setter in the request's own cycle does not block it
    req_valid = 1'b1; req_cond = 4'h0; flag_issue = 1'b1;
    #1 chk("t5_own_issue_ready", req_ready, 1);
    step();
    req_valid = 1'b0; flag_issue = 1'b0;
    chk("t5_own_valid", res_valid, 1);
    chk("t5_own_taken", res_taken, 0);
    chk("t5_own_pend", pend_cnt, 1);

    // 6: reset drops an accepted request
    status_we = 1'b1; status_in = 4'b0100;
    step();
    status_we = 1'b0;
    chk("t6_pend0", pend_cnt, 0);
    req_valid = 1'b1; req_cond = 4'h0; flag_issue = 1'b1; rst = 1'b1;
    #1 chk("t6_ready", req_ready, 1);
    step();
    rst = 1'b0; req_valid = 1'b0; flag_issue = 1'b0;
    chk("t6_valid", res_valid, 0);
    chk("t6_pend", pend_cnt, 0);
    chk("t6_status", status_out, 4'b0000);
    step();
    chk("t6_valid_after", res_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
